x_debounce: RTL and testbench

Input conditioner that drives the `x` input of the T-flip-flop state counter from a raw, asynchronous, bouncing push-button or switch. It synchronises `din` into the `CLK` domain and debounces it with a four-state Moore FSM and a stability counter. It then presents either a clean level or a single-cycle pulse on `x`. In pulse mode, each physical press advances the downstream counter by exactly one state.

---
 rtl/x_debounce.sv | 117 +++++++++++
 tb/tb_x_debounce.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/x_debounce.sv
// Push-button conditioner: two-flop synchroniser, a debounce FSM with a
// stability counter, and registered level/edge outputs feeding a counter.
module x_debounce #(
    parameter int CNT_W    = 4,
    parameter int DEBOUNCE = 4,
    parameter bit PULSE    = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic x,
    output logic lvl,
    output logic rise,
    output logic fall
);

    typedef enum logic [1:0] {
        LOW,
        RISE_CHK,
        HIGH,
        FALL_CHK
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1;
    logic             s2;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             lvl_n;
    logic             rise_n;
    logic             fall_n;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= LOW;
            cnt   <= '0;
            lvl   <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1    <= din;
            s2    <= s1;
            state <= state_n;
            cnt   <= cnt_n;
            lvl   <= lvl_n;
            rise  <= rise_n;
            fall  <= fall_n;
        end
    end

    // Any opposite sample inside a check state restarts the whole window.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lvl_n   = lvl;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        unique case (state)
            LOW: begin
                if (s2) begin
                    state_n = RISE_CHK;
                    cnt_n   = CNT_ONE;
                end else begin
                    cnt_n   = '0;
                end
            end
            RISE_CHK: begin
                if (!s2) begin
                    state_n = LOW;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = HIGH;
                    lvl_n   = 1'b1;
                    rise_n  = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n   = cnt + CNT_ONE;
                end
            end
            HIGH: begin
                if (!s2) begin
                    state_n = FALL_CHK;
                    cnt_n   = CNT_ONE;
                end else begin
                    cnt_n   = '0;
                end
            end
            FALL_CHK: begin
                if (s2) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = LOW;
                    lvl_n   = 1'b0;
                    fall_n  = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = LOW;
                cnt_n   = '0;
                lvl_n   = 1'b0;
            end
        endcase
    end

    assign x = PULSE ? rise : lvl;

endmodule

// File: tb/tb_x_debounce.sv
// Randomised and directed bench for x_debounce in both output modes,
// checked every cycle against a run-length model through a scoreboard queue.
module tb_x_debounce;

    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din = 1'b0;

    logic x_p, lvl_p, rise_p, fall_p;
    logic x_l, lvl_l, rise_l, fall_l;

    x_debounce #(.CNT_W(4), .DEBOUNCE(DB), .PULSE(1'b1)) u_p (
        .CLK(clk), .RST(rst_n), .din(din),
        .x(x_p), .lvl(lvl_p), .rise(rise_p), .fall(fall_p)
    );

    x_debounce #(.CNT_W(4), .DEBOUNCE(DB), .PULSE(1'b0)) u_l (
        .CLK(clk), .RST(rst_n), .din(din),
        .x(x_l), .lvl(lvl_l), .rise(rise_l), .fall(fall_l)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;

    // Expected {lvl, rise, fall} for the cycle just driven.
    logic [2:0] sb[$];

    // Reference: din as the FSM sees it two edges later, and a run length
    // of samples disagreeing with the accepted level.
    logic hist[$];
    logic m_lvl = 1'b0;
    logic m_rise = 1'b0;
    logic m_fall = 1'b0;
    int   m_run = 0;

    task automatic model_reset();
        hist.delete();
        m_lvl  = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_run  = 0;
    endtask

    task automatic model_edge(input logic d);
        logic samp;
        hist.push_back(d);
        samp = (hist.size() >= 3) ? hist[hist.size() - 3] : 1'b0;
        if (hist.size() > 3) void'(hist.pop_front());
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (samp != m_lvl) begin
            m_run++;
            if (m_run == DB) begin
                m_lvl  = samp;
                m_rise = samp;
                m_fall = ~samp;
                m_run  = 0;
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d",
                     name, cycle, got, exp);
        end
    endtask

    task automatic step(input logic d, input logic r);
        @(posedge clk);
        if (rst_n) model_edge(din);
        #2;
        din   = d;
        rst_n = r;
        if (!r) model_reset();
        sb.push_back({m_lvl, m_rise, m_fall});
    endtask

    task automatic run(input logic d, input int n);
        for (int i = 0; i < n; i++) step(d, 1'b1);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Monitor: compares both DUTs whenever an expectation is pending.
    initial begin
        logic [2:0] e;
        forever begin
            @(negedge clk);
            cycle++;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pulse_mode", {lvl_p, rise_p, fall_p, x_p},
                    {e, e[1]});
                chk("level_mode", {lvl_l, rise_l, fall_l, x_l},
                    {e, e[2]});
                if (rise_p) rise_cnt++;
                if (fall_p) fall_cnt++;
            end
        end
    end

    initial begin
        int r0, f0, len;
        logic lv;

        // Reset held with din high and the clock running.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        run(1'b0, 8);

        // Clean press then release.
        settle();
        r0 = rise_cnt;
        f0 = fall_cnt;
        run(1'b1, 20);
        settle();
        chk("press_rise_count", rise_cnt - r0, 1);
        chk("press_fall_count", fall_cnt - f0, 0);
        run(1'b0, 20);
        settle();
        chk("release_fall_count", fall_cnt - f0, 1);

        // Glitch of DEBOUNCE-1 samples.
        r0 = rise_cnt;
        run(1'b1, DB - 1);
        run(1'b0, 12);
        settle();
        chk("glitch_rise_count", rise_cnt - r0, 0);
        chk("glitch_lvl", lvl_p, 0);

        // Bounce then steady high.
        r0 = rise_cnt;
        run(1'b1, 1);
        run(1'b0, 1);
        run(1'b1, 2);
        run(1'b0, 1);
        run(1'b1, 20);
        settle();
        chk("bounce_rise_count", rise_cnt - r0, 1);
        run(1'b0, 12);

        // Reset after two accepted high samples, din still high on release.
        settle();
        r0 = rise_cnt;
        run(1'b1, 4);
        step(1'b1, 1'b0);
        settle();
        chk("async_reset_lvl", lvl_p, 0);
        step(1'b1, 1'b0);
        run(1'b1, 15);
        settle();
        chk("midreset_rise_count", rise_cnt - r0, 1);
        chk("midreset_lvl", lvl_p, 1);
        run(1'b0, 12);

        // Random bursts with occasional asynchronous resets.
        for (int b = 0; b < 150; b++) begin
            lv  = 1'($urandom_range(0, 1));
            len = (($urandom_range(0, 3)) == 0) ?
                  int'($urandom_range(5, 12)) : int'($urandom_range(1, 5));
            if ($urandom_range(0, 19) == 0) begin
                for (int i = 0; i < int'($urandom_range(1, 3)); i++)
                    step(lv, 1'b0);
            end
            run(lv, len);
        end
        run(1'b0, 12);

        settle();
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
